dffn_pipe: RTL and testbench

//   Parametrised bank of negative-edge-triggered D flip-flops arranged as a

---
 rtl/dffn_pipe.sv | 100 ++++++++++
 tb/tb_dffn_pipe.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dffn_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dffn_pipe
// Brief    : DEPTH-stage, WIDTH-bit falling-edge register pipeline with a
//            valid bit per stage, hold enable, synchronous load of a
//            programmable reset value, occupancy count and a serial scan
//            chain through every data bit.
// Revision : 1.0  initial release
// ============================================================================
module dffn_pipe #(
  parameter int                 WIDTH     = 8,
  parameter int                 DEPTH     = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         EN,
  input  logic                         SE,
  input  logic                         SI,
  input  logic [WIDTH-1:0]             D,
  input  logic                         VI,
  output logic [WIDTH-1:0]             Q,
  output logic [WIDTH-1:0]             QN,
  output logic                         VO,
  output logic                         SO,
  output logic [$clog2(DEPTH+1)-1:0]   FILL
);

  localparam int FW   = $clog2(DEPTH+1);
  localparam int BITS = DEPTH * WIDTH;

  // Stage DEPTH-1 occupies the most significant slot, so the flattened
  // vector doubles as the scan chain with SI entering at bit 0.
  logic [DEPTH-1:0][WIDTH-1:0] r_data;
  logic [DEPTH-1:0]            r_valid;

  logic [DEPTH-1:0][WIDTH-1:0] w_shift_data;
  logic [DEPTH-1:0]            w_shift_valid;
  logic [DEPTH-1:0][WIDTH-1:0] w_scan_data;
  logic [BITS-1:0]             w_flat;
  logic [FW-1:0]               w_fill;

  assign w_flat = r_data;

  // Functional shift: a single stage simply captures the inputs.
  if (DEPTH == 1) begin : g_shift_single
    assign w_shift_data  = D;
    assign w_shift_valid = VI;
  end else begin : g_shift_multi
    assign w_shift_data  = {r_data[DEPTH-2:0], D};
    assign w_shift_valid = {r_valid[DEPTH-2:0], VI};
  end

  // Scan shift: the whole data array moves up one bit position per edge.
  if (BITS == 1) begin : g_scan_single
    assign w_scan_data = SI;
  end else begin : g_scan_multi
    assign w_scan_data = {w_flat[BITS-2:0], SI};
  end

  // Falling-edge state update, priority reset > scan > shift/hold. Unknown
  // RST or SE poisons all state; an unknown EN merges shift and hold values
  // bitwise, so only bits that would differ go unknown.
  always_ff @(negedge CLK) begin
    case ({RST, SE})
      2'b10, 2'b11: begin
        r_data  <= {DEPTH{RESET_VAL}};
        r_valid <= '0;
      end
      2'b01: begin
        r_data  <= w_scan_data;
        r_valid <= '0;
      end
      2'b00: begin
        r_data  <= EN ? w_shift_data  : r_data;
        r_valid <= EN ? w_shift_valid : r_valid;
      end
      default: begin
        r_data  <= 'x;
        r_valid <= 'x;
      end
    endcase
  end

  // Occupancy is a popcount of registered valid bits only.
  always_comb begin
    w_fill = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_fill = w_fill + FW'(r_valid[k]);
    end
  end

  assign Q    = r_data[DEPTH-1];
  assign QN   = ~r_data[DEPTH-1];
  assign VO   = r_valid[DEPTH-1];
  assign SO   = r_data[DEPTH-1][WIDTH-1];
  assign FILL = w_fill;

endmodule
`default_nettype wire

// File: tb/tb_dffn_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dffn_pipe
// Brief    : Directed bench for dffn_pipe (WIDTH=8, DEPTH=3, RESET_VAL=A5).
// Revision : 1.0  initial release
// ============================================================================
module tb_dffn_pipe;

  logic       clk;
  logic       rst, en, se, si, vi;
  logic [7:0] d;
  logic [7:0] q, qn;
  logic       vo, so;
  logic [1:0] fill;

  int checks = 0;
  int errors = 0;

  dffn_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) dut (
    .CLK(clk), .RST(rst), .EN(en), .SE(se), .SI(si), .D(d), .VI(vi),
    .Q(q), .QN(qn), .VO(vo), .SO(so), .FILL(fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance past the next falling edge and settle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] eq, input logic ev, input logic [1:0] ef);
    check({tag, ".Q"},    32'(q),    32'(eq));
    check({tag, ".VO"},   32'(vo),   32'(ev));
    check({tag, ".FILL"}, 32'(fill), 32'(ef));
  endtask

  logic [23:0] scan_vec;

  initial begin
    rst = 1'b0; en = 1'b0; se = 1'b0; si = 1'b0; vi = 1'b0; d = 8'h00;
    #1;

    // 1. reset
    rst = 1'b1;
    tick();
    check_out("reset", 8'hA5, 1'b0, 2'd0);
    check("reset.QN", 32'(qn), 32'h5A);
    check("reset.SO", 32'(so), 32'h1);

    // 2. fill with 11,22,33
    rst = 1'b0; en = 1'b1; vi = 1'b1;
    d = 8'h11; tick(); check_out("fill1", 8'hA5, 1'b0, 2'd1);
    d = 8'h22; tick(); check_out("fill2", 8'hA5, 1'b0, 2'd2);
    d = 8'h33; tick(); check_out("fill3", 8'h11, 1'b1, 2'd3);
    check("fill3.QN", 32'(qn), 32'hEE);

    // 3. hold 4 edges with D=FF, then drain with VI=0
    en = 1'b0; d = 8'hFF; vi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("hold", 8'h11, 1'b1, 2'd3);
    end
    en = 1'b1; vi = 1'b0; d = 8'h00;
    tick(); check_out("drain1", 8'h22, 1'b1, 2'd2);
    tick(); check_out("drain2", 8'h33, 1'b1, 2'd1);
    tick(); check_out("drain3", 8'h00, 1'b0, 2'd0);

    // 4. load 80,02,01 then scan out 24 bits
    vi = 1'b1;
    d = 8'h80; tick();
    d = 8'h02; tick();
    d = 8'h01; tick();
    check_out("scanload", 8'h80, 1'b1, 2'd3);
    en = 1'b0; vi = 1'b0; se = 1'b1; si = 1'b0;
    scan_vec = 24'h80_02_01;
    for (int i = 0; i < 24; i++) begin
      check("scan.SO", 32'(so), 32'(scan_vec[23-i]));
      tick();
      if (i == 0) begin
        check("scan1.VO", 32'(vo), 32'h0);
        check("scan1.FILL", 32'(fill), 32'h0);
      end
    end
    check_out("scandone", 8'h00, 1'b0, 2'd0);

    // 5. reset with EN=1 and two words in flight
    se = 1'b0; en = 1'b1; vi = 1'b1;
    d = 8'h66; tick();
    d = 8'h77; tick();
    check("inflight.FILL", 32'(fill), 32'h2);
    rst = 1'b1; d = 8'h99; tick();
    check_out("rstmid", 8'hA5, 1'b0, 2'd0);
    rst = 1'b0; d = 8'h44; vi = 1'b1; tick();
    check_out("post1", 8'hA5, 1'b0, 2'd1);
    d = 8'h00; vi = 1'b0; tick();
    check_out("post2", 8'hA5, 1'b0, 2'd1);
    tick();
    check_out("post3", 8'h44, 1'b1, 2'd1);

    // 6. toggle D/EN only while CLK is high
    @(posedge clk);
    #1;
    en = 1'b0; d = 8'hC3; vi = 1'b1;
    #1 en = 1'b1; d = 8'h3C;
    #1 en = 1'b0; d = 8'hFF;
    #1 en = 1'b1; d = 8'h12;
    check_out("clkhigh", 8'h44, 1'b1, 2'd1);
    check("clkhigh.QN", 32'(qn), 32'hBB);
    en = 1'b0;
    tick();
    check_out("clkhigh_after", 8'h44, 1'b1, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
